// File: rtl/fb_writer_if.sv
// Pixel-input and framebuffer-write bundle for fb_writer.
interface fb_writer_if #(
  parameter int FB_ADDRW      = 16,
  parameter int FB_COLOR_BITS = 9
);
  logic [31:0]              Draw_X;
  logic [31:0]              Draw_Y;
  logic [31:0]              Draw_Color;
  logic                     Enable_Draw;
  logic                     frame_start;
  logic                     fb_wr_ready;
  logic                     fb_wr_en;
  logic [FB_ADDRW-1:0]      fb_wr_addr;
  logic [FB_COLOR_BITS-1:0] fb_wr_data;
  logic [15:0]              clip_count;
  logic                     overflow;
  logic                     busy;

  modport master (
    output Draw_X, Draw_Y, Draw_Color, Enable_Draw, frame_start, fb_wr_ready,
    input  fb_wr_en, fb_wr_addr, fb_wr_data, clip_count, overflow, busy
  );

  modport slave (
    input  Draw_X, Draw_Y, Draw_Color, Enable_Draw, frame_start, fb_wr_ready,
    output fb_wr_en, fb_wr_addr, fb_wr_data, clip_count, overflow, busy
  );
endinterface

// File: rtl/fb_writer.sv
// Pixel writer: input register, clip, FIFO, registered framebuffer write port.
// Define FB_WRITER_CLEAR_EN to build in the frame-clear FSM (RUN/CLEAR).
module fb_writer #(
  parameter int FB_WIDTH      = 160,
  parameter int FB_HEIGHT     = 120,
  parameter int FB_COLOR_BITS = 9,
  parameter int FB_ADDRW      = 16,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic        clk,
  input  logic        reset,
  fb_writer_if.slave  bus
);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [FB_ADDRW-1:0]      addr;
    logic [FB_COLOR_BITS-1:0] color;
  } pix_t;

  // Stage 1: input register
  logic                     s1_vld;
  logic [31:0]              s1_x, s1_y;
  logic [FB_COLOR_BITS-1:0] s1_color;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
      s1_color <= '0;
    end else begin
      s1_vld   <= bus.Enable_Draw;
      s1_x     <= bus.Draw_X;
      s1_y     <= bus.Draw_Y;
      s1_color <= bus.Draw_Color[FB_COLOR_BITS-1:0];
    end
  end

  // Stage 2: clip and address (Y*160 via shifts), feeds the FIFO push
  logic clipped, push_req, push, pop, in_run, clr_wr;
  logic [FB_ADDRW-1:0] clr_cnt;
  pix_t s2_pix;

  assign clipped  = s1_vld && (s1_x >= 32'(FB_WIDTH) || s1_y >= 32'(FB_HEIGHT));
  assign push_req = s1_vld && !clipped;
  assign s2_pix   = '{addr:  FB_ADDRW'((s1_y << 7) + (s1_y << 5) + s1_x),
                      color: s1_color};

  // FIFO with one extra pointer bit to tell full from empty
  pix_t        mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic        empty, full;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop   = !empty && bus.fb_wr_ready && in_run;
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= s2_pix;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      bus.clip_count <= '0;
      bus.overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (clipped && bus.clip_count != 16'hFFFF)
        bus.clip_count <= bus.clip_count + 16'd1;
      if (push_req && !push)
        bus.overflow <= 1'b1;
    end
  end

`ifdef FB_WRITER_CLEAR_EN
  localparam logic [FB_ADDRW-1:0] LAST_ADDR = FB_ADDRW'(FB_WIDTH * FB_HEIGHT - 1);

  typedef enum logic [0:0] {S_RUN, S_CLEAR} state_t;
  state_t              state, state_nxt;
  logic [FB_ADDRW-1:0] clr_cnt_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_RUN;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // frame_start is only honoured in RUN; a clear in progress runs to completion
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_wr      = 1'b0;
    case (state)
      S_RUN: begin
        if (bus.frame_start) begin
          state_nxt   = S_CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (bus.fb_wr_ready) begin
          clr_wr      = 1'b1;
          clr_cnt_nxt = clr_cnt + 1'b1;
          if (clr_cnt == LAST_ADDR) state_nxt = S_RUN;
        end
      end
      default: state_nxt = S_RUN;
    endcase
  end

  assign in_run   = (state == S_RUN);
  assign bus.busy = (state == S_CLEAR);
`else
  logic unused_frame_start;
  assign unused_frame_start = bus.frame_start;
  assign in_run   = 1'b1;
  assign clr_wr   = 1'b0;
  assign clr_cnt  = '0;
  assign bus.busy = 1'b0;
`endif

  logic unused_color;
  assign unused_color = ^bus.Draw_Color[31:FB_COLOR_BITS];

  // Registered write port; addr/data hold when no write is issued
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.fb_wr_en   <= 1'b0;
      bus.fb_wr_addr <= '0;
      bus.fb_wr_data <= '0;
    end else begin
      bus.fb_wr_en <= pop || clr_wr;
      if (pop) begin
        bus.fb_wr_addr <= mem[rd_ptr[PW-1:0]].addr;
        bus.fb_wr_data <= mem[rd_ptr[PW-1:0]].color;
      end else if (clr_wr) begin
        bus.fb_wr_addr <= clr_cnt;
        bus.fb_wr_data <= '0;
      end
    end
  end
endmodule

// File: tb/tb_fb_writer.sv
// Randomized bench for fb_writer against a queue-based model, plus directed pins.
module tb_fb_writer;
  localparam int DEPTH = 8;
`ifdef FB_WRITER_CLEAR_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fb_writer_if #(.FB_ADDRW(16), .FB_COLOR_BITS(9)) bus();
  fb_writer #(.FIFO_DEPTH(DEPTH)) dut (.clk(clk), .reset(rst_n), .bus(bus.slave));

  int tests = 0, fails = 0;

  // model state
  bit          m_s1_v;
  logic [31:0] m_s1_x, m_s1_y;
  logic [8:0]  m_s1_c;
  int unsigned qa[$];
  logic [8:0]  qd[$];
  bit          m_en, m_ovf, m_clear;
  int unsigned m_addr, m_cnt, m_clip;
  logic [8:0]  m_data;

  // observed DUT write statistics
  int          wr_cnt, zero_cnt;
  int unsigned last_px_addr;
  logic [8:0]  last_px_data;

  task automatic model_reset();
    m_s1_v = 0; qa.delete(); qd.delete();
    m_en = 0; m_ovf = 0; m_clear = 0; m_addr = 0; m_data = 0; m_cnt = 0; m_clip = 0;
  endtask

  task automatic model_edge();
    bit pop, clr;
    pop = !m_clear && bus.fb_wr_ready && qa.size() > 0;
    clr = m_clear && bus.fb_wr_ready;
    m_en = pop || clr;
    if (pop) begin
      m_addr = qa.pop_front();
      m_data = qd.pop_front();
    end else if (clr) begin
      m_addr = m_cnt;
      m_data = 9'd0;
    end
    if (m_s1_v) begin
      if (m_s1_x >= 160 || m_s1_y >= 120) begin
        if (m_clip < 65535) m_clip++;
      end else if (qa.size() < DEPTH) begin
        qa.push_back(m_s1_y * 160 + m_s1_x);
        qd.push_back(m_s1_c);
      end else m_ovf = 1;
    end
    if (m_clear) begin
      if (clr) begin
        if (m_cnt == 160 * 120 - 1) m_clear = 0;
        m_cnt++;
      end
    end else if (CLR_EN && bus.frame_start) begin
      m_clear = 1;
      m_cnt = 0;
    end
    m_s1_v = bus.Enable_Draw;
    m_s1_x = bus.Draw_X;
    m_s1_y = bus.Draw_Y;
    m_s1_c = bus.Draw_Color[8:0];
  endtask

  task automatic check();
    tests++;
    if (bus.fb_wr_en !== m_en || bus.fb_wr_addr !== 16'(m_addr) || bus.fb_wr_data !== m_data ||
        bus.clip_count !== 16'(m_clip) || bus.overflow !== m_ovf || bus.busy !== m_clear) begin
      fails++;
      $display("FAIL cycle@%0t en/addr/data/clip/ovf/busy got %b/%0d/%h/%0d/%b/%b want %b/%0d/%h/%0d/%b/%b",
               $time, bus.fb_wr_en, bus.fb_wr_addr, bus.fb_wr_data, bus.clip_count, bus.overflow,
               bus.busy, m_en, m_addr, m_data, m_clip, m_ovf, m_clear);
    end
    if (bus.fb_wr_en === 1'b1) begin
      wr_cnt++;
      if (bus.fb_wr_data == 9'd0) zero_cnt++;
      else begin
        last_px_addr = bus.fb_wr_addr;
        last_px_data = bus.fb_wr_data;
      end
    end
  endtask

  task automatic lit(string name, longint got, longint want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got %0d want %0d", name, got, want);
    end
  endtask

  // inputs change only at negedge; model and DUT both advance on posedge
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
    check();
  endtask

  task automatic set_px(bit en, logic [31:0] x, logic [31:0] y, logic [31:0] c);
    bus.Enable_Draw = en; bus.Draw_X = x; bus.Draw_Y = y; bus.Draw_Color = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    set_px(0, 0, 0, 0);
    bus.frame_start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check();
    rst_n = 1'b1;
    wr_cnt = 0; zero_cnt = 0;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.fb_wr_ready = 1'b1;
    bus.frame_start = 1'b0;
    set_px(0, 0, 0, 0);
    @(negedge clk);
    do_reset();
    lit("reset_en", bus.fb_wr_en, 0);
    lit("reset_addr", bus.fb_wr_addr, 0);
    lit("reset_clip", bus.clip_count, 0);
    lit("reset_busy", bus.busy, 0);

    // single pixel latency: visible in cycle N+3
    bus.fb_wr_ready = 1'b1;
    set_px(1, 5, 2, 32'hFFFF_F1A5);
    step();
    set_px(0, 0, 0, 0);
    step();
    lit("lat_n2_en", bus.fb_wr_en, 0);
    step();
    lit("lat_n3_en", bus.fb_wr_en, 1);
    lit("lat_n3_addr", bus.fb_wr_addr, 325);
    lit("lat_n3_data", bus.fb_wr_data, 9'h1A5);
    step();
    lit("lat_n4_en", bus.fb_wr_en, 0);
    lit("lat_hold_addr", bus.fb_wr_addr, 325);

    // clipping
    do_reset();
    set_px(1, 160, 0, 1); step();
    set_px(1, 0, 120, 2); step();
    set_px(1, 32'hFFFF_FFFF, 0, 3); step();
    set_px(0, 7, 7, 4); step(); step(); step();
    lit("clip_count", bus.clip_count, 3);
    lit("clip_writes", wr_cnt, 0);

    // overflow: ready low, 10 pixels into an 8-deep FIFO
    do_reset();
    bus.fb_wr_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_px(1, i, 1, 32'h100 + i);
      step();
    end
    set_px(0, 0, 0, 0);
    step(); step();
    lit("ovf_set", bus.overflow, 1);
    bus.fb_wr_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();
    lit("ovf_drained", wr_cnt, 8);
    lit("ovf_last_addr", bus.fb_wr_addr, 160 + 7);

    // full FIFO with concurrent pop accepts one push per cycle
    do_reset();
    bus.fb_wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_px(1, 20 + i, 9, 32'h40 + i);
      step();
    end
    set_px(0, 0, 0, 0);
    step();
    bus.fb_wr_ready = 1'b1;
    wr_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      set_px(1, i, 50, 32'h80 + i);
      step();
    end
    lit("full_pop_writes", wr_cnt, 30);
    lit("full_pop_ovf", bus.overflow, 0);
    set_px(0, 0, 0, 0);
    for (int i = 0; i < 12; i++) step();

    // reset mid-drain discards queued pixels
    bus.fb_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_px(1, i, 3, 32'h11);
      step();
    end
    set_px(0, 0, 0, 0);
    step(); step();
    do_reset();
    bus.fb_wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
    lit("drain_reset_writes", wr_cnt, 0);

    // randomized traffic
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(0, 100);
      for (int i = 0; i < 100; i++) begin
        logic [31:0] x, y;
        x = $urandom_range(0, 180);
        y = $urandom_range(0, 135);
        if ($urandom_range(0, 31) == 0) x = 32'hFFFF_FFFF;
        if ($urandom_range(0, 31) == 0) y = $urandom;
        bus.fb_wr_ready = ($urandom_range(1, 100) <= rdy_pct);
        set_px($urandom_range(0, 3) != 0, x, y, $urandom);
        step();
      end
    end
    set_px(0, 0, 0, 0);
    bus.fb_wr_ready = 1'b1;
    for (int i = 0; i < 12; i++) step();

    // frame_start must be ignored without the clear FSM
    if (!CLR_EN) begin
      bus.frame_start = 1'b1; step(); bus.frame_start = 1'b0; step();
      lit("no_clear_busy", bus.busy, 0);
    end

`ifdef FB_WRITER_CLEAR_EN
    begin
      int guard;
      do_reset();
      bus.fb_wr_ready = 1'b1;
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      set_px(1, 7, 3, 32'h55);
      step();
      set_px(0, 0, 0, 0);
      lit("clear_busy", bus.busy, 1);
      guard = 0;
      while (m_clear && guard < 25000) begin
        bus.fb_wr_ready = ($urandom_range(0, 7) != 0);
        bus.frame_start = (m_cnt == 100);
        step();
        guard++;
      end
      bus.frame_start = 1'b0;
      lit("clear_guard", guard < 25000, 1);
      lit("clear_zero_writes", zero_cnt, 19200);
      lit("clear_busy_done", bus.busy, 0);
      lit("clear_last_addr", bus.fb_wr_addr, 19199);
      bus.fb_wr_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
      lit("clear_queued_addr", last_px_addr, 487);
      lit("clear_queued_data", last_px_data, 9'h55);

      // reset in the middle of a clear
      do_reset();
      bus.frame_start = 1'b1;
      step();
      bus.frame_start = 1'b0;
      guard = 0;
      while (m_cnt < 500 && guard < 1000) begin step(); guard++; end
      do_reset();
      lit("mid_clear_en", bus.fb_wr_en, 0);
      lit("mid_clear_addr", bus.fb_wr_addr, 0);
      lit("mid_clear_busy", bus.busy, 0);
      for (int i = 0; i < 20; i++) step();
      lit("mid_clear_writes", wr_cnt, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 160, framebuffer width in pixels.
REQ-002 SHALL have parameter FB_HEIGHT, default 120, framebuffer height in pixels.
REQ-003 SHALL have parameter FB_COLOR_BITS, default 9, pixel colour width.
REQ-004 SHALL have parameter FB_ADDRW, default 16, framebuffer address width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8, pixel FIFO entries (power of 2).
REQ-006 SHALL use one clock and an asynchronous, active-low reset; ports follow.
REQ-007 clk  input  1  system clock, all logic on rising edge.
REQ-008 reset  input  1  asynchronous active-low reset.
REQ-009 Draw_X  input  32  pixel X from blitter stage, unsigned.
REQ-010 Draw_Y  input  32  pixel Y from blitter stage, unsigned.
REQ-011 Draw_Color  input  32  pixel colour; only [FB_COLOR_BITS-1:0] used.
REQ-012 Enable_Draw  input  1  pixel valid, sampled every cycle.
REQ-013 frame_start  input  1  one-cycle frame boundary pulse.
REQ-014 fb_wr_ready  input  1  framebuffer write port granted this cycle.
REQ-015 fb_wr_en  output  1  framebuffer write strobe.
REQ-016 fb_wr_addr  output  FB_ADDRW  framebuffer write address.
REQ-017 fb_wr_data  output  FB_COLOR_BITS  framebuffer write colour.
REQ-018 clip_count  output  16  pixels dropped by clipping, saturating.
REQ-019 overflow  output  1  sticky: pixel dropped due to full FIFO.
REQ-020 busy  output  1  frame clear in progress.

Function
REQ-021 Stage 1 SHALL register Draw_X, Draw_Y, Draw_Color[8:0], Enable_Draw each cycle.
REQ-022 Stage 2 SHALL clip: valid pixel with X >= FB_WIDTH or Y >= FB_HEIGHT dropped, clip_count +1, saturating at 16'hFFFF.
REQ-023 Address SHALL be Y*160 + X computed as (Y<<7)+(Y<<5)+X, truncated to FB_ADDRW; range 0..19199.
REQ-024 Unclipped pixel SHALL be pushed {addr,colour} into FIFO; if full and no pop this cycle, dropped and overflow set until reset.
REQ-025 Full FIFO with simultaneous pop SHALL accept the push.
REQ-026 Pop SHALL occur when FIFO non-empty and fb_wr_ready high and state RUN; registered outputs fb_wr_en=1, addr/data from head, next cycle.
REQ-027 fb_wr_en SHALL be 0 in every cycle without a pop; addr/data hold last value.
REQ-028 Latency: pixel valid at cycle N, FIFO empty, ready high -> fb_wr_en high in cycle N+3.
REQ-029 Pixel order SHALL be preserved; no bypass of the FIFO.
REQ-030 Enable_Draw low SHALL push nothing and not count as clipped.

Reset
REQ-031 On reset low: fb_wr_en=0, fb_wr_addr=0, fb_wr_data=0, clip_count=0, overflow=0, busy=0, FIFO empty, stage regs invalid, state RUN.
REQ-032 Reset asserted mid-clear or mid-FIFO drain SHALL discard all pending work; no write after release until new input.

Configuration
REQ-033 Macro FB_WRITER_CLEAR_EN SHALL compile in the frame-clear FSM.
REQ-034 With macro: states RUN, CLEAR; frame_start in RUN -> CLEAR, busy=1, clear counter=0.
REQ-035 In CLEAR: each cycle with fb_wr_ready high write colour 0 to counter address, counter +1; after address FB_WIDTH*FB_HEIGHT-1 written -> RUN, busy=0.
REQ-036 In CLEAR: FIFO pops stalled, pushes continue (overflow rules apply); frame_start ignored.
REQ-037 Without macro: only RUN exists, frame_start ignored, busy constant 0.

Verification
REQ-038 Pixel X=5,Y=2,colour 9'h1A5, ready high -> cycle N+3 fb_wr_en=1, addr=325, data=9'h1A5.
REQ-039 Pixel X=160,Y=0 then X=0,Y=120 then X=32'hFFFFFFFF -> no writes, clip_count=3.
REQ-040 ready low, 10 consecutive valid pixels (depth 8) -> 8 buffered (+pipeline), overflow=1; ready high -> buffered pixels written in order.
REQ-041 Full FIFO, ready high, new pixel every cycle -> no drop, overflow stays 0, one write per cycle.
REQ-042 FB_WRITER_CLEAR_EN: frame_start, ready high -> 19200 writes data 0 addr 0..19199, busy low after last; queued pixel then written.
REQ-043 Reset low during clear at address 500 -> outputs 0, busy 0, no further writes after release.
